tl_ul_arb2: RTL
===============

TL_UL_ARB2 -- requirements
Module: tl_ul_arb2

Interface
REQ-001 Parameter SRC_W, default 1: upstream source-ID width per master.
REQ-002 Parameter MAX_OUT, default 2: maximum outstanding A-requests per master (range 1..7).
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 mN_a_valid / mN_a_ready (N=0,1)  in / out  1  upstream A-channel handshake.
REQ-006 mN_a_opcode, mN_a_param / mN_a_size  input  3 / 2  A-channel command fields.
REQ-007 mN_a_source / mN_a_address / mN_a_mask / mN_a_data  input  SRC_W / 32 / 4 / 32  A-channel payload.
REQ-008 mN_d_valid / mN_d_ready  out / in  1  upstream D-channel handshake.
REQ-009 mN_d_opcode, mN_d_param, mN_d_size, mN_d_source, mN_d_data, mN_d_error  output  3,3,2,SRC_W,32,1  D-channel fields.
REQ-010 s_a_*  output  same widths, except s_a_source SRC_W+1  downstream A channel; s_a_ready is an input.
REQ-011 s_d_*  input  same widths, except s_d_source SRC_W+1  downstream D channel; s_d_ready is an output.
REQ-012 err_route  output  1  sticky flag: D response routed to a master with zero outstanding.

Function
REQ-013 All transfers are single-beat TL-UL; a beat transfers when valid and ready are both high on a rising edge.
REQ-014 A master is eligible when mN_a_valid=1 and its outstanding count < MAX_OUT.
REQ-015 Arbitration is round-robin: the master not granted last has priority; the pointer toggles only on an s_a fire.
REQ-016 Grant is combinational from eligibility when unlocked; zero added latency, s_a_valid = granted master's a_valid.
REQ-017 While s_a_valid=1 and s_a_ready=0, the grant is locked: no grant change until fire; lock clears on fire.
REQ-018 s_a_source = {grant index, mN_a_source}; all other s_a fields pass through from the granted master unchanged.
REQ-019 mN_a_ready = s_a_ready AND granted(N) AND eligible(N); the non-granted master sees a_ready=0.
REQ-020 Outstanding counter N: +1 on A fire from N, -1 on D fire to N, unchanged on both in one cycle; width ceil(log2(MAX_OUT+1)).
REQ-021 D routing: s_d_source MSB selects master; mN_d_valid = s_d_valid AND selected; mN_d_source = s_d_source low SRC_W bits.
REQ-022 s_d_ready = mN_d_ready of the selected master; D path is combinational, no buffering.
REQ-023 D fire to a master whose count is 0: counter holds at 0 (no underflow) and err_route sets until reset.
REQ-024 At count = MAX_OUT the master is ineligible; a same-cycle D fire frees the slot starting next cycle.
REQ-025 Both masters ineligible: s_a_valid=0, pointer and lock unchanged.

Reset
REQ-026 reset_n low asynchronously clears both counters, lock, err_route; pointer set to favour master 0.
REQ-027 During reset all s_a_valid, mN_a_ready, mN_d_valid, s_d_ready outputs are 0.
REQ-028 Reset mid-transaction discards all outstanding state; no replay.

Structure
REQ-029 TL-UL opcode constants (Get=4, PutFull=0, PutPartial=1, AccessAck=0, AccessAckData=1) and the A/D field widths live in the shared TL package.
REQ-030 One sub-module, tl_out_cnt (saturating up/down counter with at-max and zero flags), is instantiated once per master.

Verification
REQ-031 Both masters assert Get continuously, s_a_ready=1, responses returned immediately -> grants alternate m0,m1,m0,m1; s_a_source MSB 0,1,0,1.
REQ-032 m0 valid, s_a_ready=0 for 3 cycles, m1 asserts in cycle 2 -> s_a stays on m0 until fire, m1 granted next cycle.
REQ-033 MAX_OUT=2, m0 issues 2 Gets with no D -> third held with m0_a_ready=0; one AccessAckData to m0 -> third accepted next cycle.
REQ-034 s_d_source=2'b10, opcode AccessAckData, data 0xDEADBEEF, m1_d_ready=0 then 1 -> s_d_ready follows m1_d_ready; m1 receives data, source 0.
REQ-035 D response with MSB=1 while m1 count=0 -> err_route=1, m1 counter stays 0; reset_n pulse -> err_route=0.
REQ-036 reset_n asserted with m0 count=2 -> counters 0, s_a_valid=0 immediately; after release m0 is granted first.

Source files
------------

// File: rtl/tl_ul_arb2_pkg.sv
// Shared TL-UL definitions: opcode constants, channel field widths and a
// counter-width helper used by the two-master arbiter.
package tl_ul_arb2_pkg;

  localparam int unsigned TlOpW    = 3;
  localparam int unsigned TlParamW = 3;
  localparam int unsigned TlSizeW  = 2;
  localparam int unsigned TlAddrW  = 32;
  localparam int unsigned TlDataW  = 32;
  localparam int unsigned TlMaskW  = 4;

  localparam logic [TlOpW-1:0] OpPutFull       = 3'd0;
  localparam logic [TlOpW-1:0] OpPutPartial    = 3'd1;
  localparam logic [TlOpW-1:0] OpGet           = 3'd4;
  localparam logic [TlOpW-1:0] OpAccessAck     = 3'd0;
  localparam logic [TlOpW-1:0] OpAccessAckData = 3'd1;

  // Bits needed to hold 0..max_out inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/tl_out_cnt.sv
// Saturating up/down outstanding-request counter with at-max and zero flags.
// Simultaneous inc and dec leave the count unchanged.
module tl_out_cnt #(
  parameter int unsigned MAX = 2,
  parameter int unsigned W   = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic dec,
  output logic at_max,
  output logic is_zero
);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max  = (cnt_q == W'(MAX));
  assign is_zero = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !at_max) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec && !inc && !is_zero) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tl_ul_arb2.sv
// Two-master TL-UL arbiter: round-robin A-channel grant with stall lock,
// per-master outstanding limits, and source-MSB based D-channel routing.
module tl_ul_arb2
  import tl_ul_arb2_pkg::*;
#(
  parameter int unsigned SRC_W   = 1,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                m0_a_valid,
  output logic                m0_a_ready,
  input  logic [TlOpW-1:0]    m0_a_opcode,
  input  logic [TlParamW-1:0] m0_a_param,
  input  logic [TlSizeW-1:0]  m0_a_size,
  input  logic [SRC_W-1:0]    m0_a_source,
  input  logic [TlAddrW-1:0]  m0_a_address,
  input  logic [TlMaskW-1:0]  m0_a_mask,
  input  logic [TlDataW-1:0]  m0_a_data,
  output logic                m0_d_valid,
  input  logic                m0_d_ready,
  output logic [TlOpW-1:0]    m0_d_opcode,
  output logic [TlParamW-1:0] m0_d_param,
  output logic [TlSizeW-1:0]  m0_d_size,
  output logic [SRC_W-1:0]    m0_d_source,
  output logic [TlDataW-1:0]  m0_d_data,
  output logic                m0_d_error,
  input  logic                m1_a_valid,
  output logic                m1_a_ready,
  input  logic [TlOpW-1:0]    m1_a_opcode,
  input  logic [TlParamW-1:0] m1_a_param,
  input  logic [TlSizeW-1:0]  m1_a_size,
  input  logic [SRC_W-1:0]    m1_a_source,
  input  logic [TlAddrW-1:0]  m1_a_address,
  input  logic [TlMaskW-1:0]  m1_a_mask,
  input  logic [TlDataW-1:0]  m1_a_data,
  output logic                m1_d_valid,
  input  logic                m1_d_ready,
  output logic [TlOpW-1:0]    m1_d_opcode,
  output logic [TlParamW-1:0] m1_d_param,
  output logic [TlSizeW-1:0]  m1_d_size,
  output logic [SRC_W-1:0]    m1_d_source,
  output logic [TlDataW-1:0]  m1_d_data,
  output logic                m1_d_error,
  output logic                s_a_valid,
  input  logic                s_a_ready,
  output logic [TlOpW-1:0]    s_a_opcode,
  output logic [TlParamW-1:0] s_a_param,
  output logic [TlSizeW-1:0]  s_a_size,
  output logic [SRC_W:0]      s_a_source,
  output logic [TlAddrW-1:0]  s_a_address,
  output logic [TlMaskW-1:0]  s_a_mask,
  output logic [TlDataW-1:0]  s_a_data,
  input  logic                s_d_valid,
  output logic                s_d_ready,
  input  logic [TlOpW-1:0]    s_d_opcode,
  input  logic [TlParamW-1:0] s_d_param,
  input  logic [TlSizeW-1:0]  s_d_size,
  input  logic [SRC_W:0]      s_d_source,
  input  logic [TlDataW-1:0]  s_d_data,
  input  logic                s_d_error,
  output logic                err_route
);

  localparam int unsigned CntW = cnt_width(MAX_OUT);

  logic elig0, elig1, at_max0, at_max1, zero0, zero1;
  logic grant, d_sel, d_fire0, d_fire1;
  logic prio_q, prio_d;  // index of the master favoured on a tie
  logic lock_q, lock_d, lock_idx_q, lock_idx_d;
  logic err_q, err_d;

  assign elig0 = m0_a_valid & ~at_max0;
  assign elig1 = m1_a_valid & ~at_max1;

  always_comb begin
    if (lock_q) begin
      grant = lock_idx_q;
    end else if (elig0 && elig1) begin
      grant = prio_q;
    end else begin
      grant = elig1;
    end
  end

  // Reset gating keeps handshake outputs quiet even with inputs asserted.
  assign s_a_valid  = reset_n & (grant ? elig1 : elig0);
  assign m0_a_ready = reset_n & s_a_ready & ~grant & elig0;
  assign m1_a_ready = reset_n & s_a_ready & grant & elig1;

  assign s_a_opcode  = grant ? m1_a_opcode  : m0_a_opcode;
  assign s_a_param   = grant ? m1_a_param   : m0_a_param;
  assign s_a_size    = grant ? m1_a_size    : m0_a_size;
  assign s_a_source  = grant ? {1'b1, m1_a_source} : {1'b0, m0_a_source};
  assign s_a_address = grant ? m1_a_address : m0_a_address;
  assign s_a_mask    = grant ? m1_a_mask    : m0_a_mask;
  assign s_a_data    = grant ? m1_a_data    : m0_a_data;

  always_comb begin
    prio_d     = prio_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (s_a_valid) begin
      lock_d     = ~s_a_ready;
      lock_idx_d = grant;
      if (s_a_ready) prio_d = ~grant;
    end
  end

  assign d_sel      = s_d_source[SRC_W];
  assign m0_d_valid = reset_n & s_d_valid & ~d_sel;
  assign m1_d_valid = reset_n & s_d_valid & d_sel;
  assign s_d_ready  = reset_n & (d_sel ? m1_d_ready : m0_d_ready);
  assign d_fire0    = m0_d_valid & m0_d_ready;
  assign d_fire1    = m1_d_valid & m1_d_ready;

  assign m0_d_opcode = s_d_opcode;
  assign m0_d_param  = s_d_param;
  assign m0_d_size   = s_d_size;
  assign m0_d_source = s_d_source[SRC_W-1:0];
  assign m0_d_data   = s_d_data;
  assign m0_d_error  = s_d_error;
  assign m1_d_opcode = s_d_opcode;
  assign m1_d_param  = s_d_param;
  assign m1_d_size   = s_d_size;
  assign m1_d_source = s_d_source[SRC_W-1:0];
  assign m1_d_data   = s_d_data;
  assign m1_d_error  = s_d_error;

  assign err_d     = err_q | (d_fire0 & zero0) | (d_fire1 & zero1);
  assign err_route = err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_q     <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  tl_out_cnt #(.MAX(MAX_OUT), .W(CntW)) u_cnt0 (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (m0_a_ready),
    .dec     (d_fire0),
    .at_max  (at_max0),
    .is_zero (zero0)
  );

  tl_out_cnt #(.MAX(MAX_OUT), .W(CntW)) u_cnt1 (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (m1_a_ready),
    .dec     (d_fire1),
    .at_max  (at_max1),
    .is_zero (zero1)
  );

endmodule
